// File: rtl/fp_pkg.sv
// Shared floating-point definitions: field widths, FSM states, GRS bit positions
// and packing helpers for the special results.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int MANT_W  = FRAC_W + 5;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam int S_IDX     = 0;
    localparam int R_IDX     = 1;
    localparam int G_IDX     = 2;
    localparam int LSB_IDX   = 3;
    localparam int HID_IDX   = MANT_W - 2;
    localparam int CARRY_IDX = MANT_W - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic logic [EXP_W+FRAC_W:0] pack_zero(input logic sign);
        return {sign, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
    endfunction

    function automatic logic [EXP_W+FRAC_W:0] pack_inf(input logic sign);
        return {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even of a significand with trailing G/R/S bits.
module fp_round_rne #(
    parameter int SIG_W = fp_pkg::FRAC_W + 1
) (
    input  logic [SIG_W-1:0] sig_i,
    input  logic [2:0]       grs_i,
    output logic [SIG_W-1:0] sig_o,
    output logic             carry_o,
    output logic             inexact_o
);
    import fp_pkg::*;

    logic round_up_s;

    // Round up on more than half an ulp, or exactly half with an odd lsb.
    always_comb begin
        round_up_s       = grs_i[G_IDX] & (grs_i[R_IDX] | grs_i[S_IDX] | sig_i[0]);
        {carry_o, sig_o} = {1'b0, sig_i} + {{SIG_W{1'b0}}, round_up_s};
        inexact_o        = |grs_i;
    end

endmodule

// File: rtl/fp_normalize_round.sv
// Post-add stage: iterative left normalization, RNE rounding and IEEE-754 packing
// with overflow-to-infinity and flush-to-zero.
module fp_normalize_round #(
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int FRAC_W = fp_pkg::FRAC_W,
    parameter int MANT_W = FRAC_W + 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W+1:0]        in_exp,
    input  logic [MANT_W-1:0]       in_mant,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_result,
    output logic                    out_overflow,
    output logic                    out_underflow,
    output logic                    out_inexact
);
    import fp_pkg::*;

    // One spare bit over the port width so carry and round increments cannot wrap.
    localparam int EXP_IW = EXP_W + 3;
    localparam int RES_W  = 1 + EXP_W + FRAC_W;
    localparam logic signed [EXP_IW-1:0] EXP_ONE_C  = {{(EXP_IW-1){1'b0}}, 1'b1};
    localparam logic signed [EXP_IW-1:0] EXP_ZERO_C = {EXP_IW{1'b0}};
    localparam logic signed [EXP_IW-1:0] EXP_TOP_C  = {{(EXP_IW-EXP_W){1'b0}}, {EXP_W{1'b1}}};

    state_e                    state_q;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic                      sign_q;
    logic                      ufl_q;
    logic signed [EXP_IW-1:0]  exp_q;
    logic [MANT_W-1:0]         mant_q;
    logic [RES_W-1:0]          result_q;
    logic                      ovf_q;
    logic                      unf_q;
    logic                      inx_q;

    logic [FRAC_W:0]           sig_rnd_s;
    logic                      rnd_carry_s;
    logic                      rnd_inx_s;
    logic signed [EXP_IW-1:0]  exp_rnd_s;
    logic [FRAC_W-1:0]         frac_rnd_s;

    logic [RES_W-1:0]          result_d;
    logic                      ovf_d;
    logic                      unf_d;
    logic                      inx_d;

    fp_round_rne #(.SIG_W(FRAC_W + 1)) u_round (
        .sig_i     (mant_q[HID_IDX:LSB_IDX]),
        .grs_i     (mant_q[G_IDX:S_IDX]),
        .sig_o     (sig_rnd_s),
        .carry_o   (rnd_carry_s),
        .inexact_o (rnd_inx_s)
    );

    // Rounded result and flags, consumed by the FSM in the ROUND state.
    always_comb begin
        exp_rnd_s  = exp_q;
        frac_rnd_s = sig_rnd_s[FRAC_W-1:0];
        result_d   = {RES_W{1'b0}};
        ovf_d      = 1'b0;
        unf_d      = 1'b0;
        inx_d      = 1'b0;
        if (rnd_carry_s) begin
            exp_rnd_s  = exp_q + EXP_ONE_C;
            frac_rnd_s = sig_rnd_s[FRAC_W:1];
        end else begin
            exp_rnd_s  = exp_q;
            frac_rnd_s = sig_rnd_s[FRAC_W-1:0];
        end
        if (mant_q == {MANT_W{1'b0}}) begin
            result_d = pack_zero(1'b0);
        end else if (exp_rnd_s >= EXP_TOP_C) begin
            result_d = pack_inf(sign_q);
            ovf_d    = 1'b1;
            inx_d    = 1'b1;
        end else if ((exp_rnd_s <= EXP_ZERO_C) || ufl_q) begin
            result_d = pack_zero(sign_q);
            unf_d    = 1'b1;
            inx_d    = 1'b1;
        end else begin
            result_d = {sign_q, exp_rnd_s[EXP_W-1:0], frac_rnd_s};
            inx_d    = rnd_inx_s;
        end
    end

    // Control FSM together with the datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sign_q      <= 1'b0;
            ufl_q       <= 1'b0;
            exp_q       <= EXP_ZERO_C;
            mant_q      <= {MANT_W{1'b0}};
            result_q    <= {RES_W{1'b0}};
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        sign_q     <= in_sign;
                        exp_q      <= {in_exp[EXP_W+1], in_exp};
                        mant_q     <= in_mant;
                        ufl_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= NORM;
                    end else begin
                        state_q    <= IDLE;
                    end
                end
                NORM: begin
                    if (mant_q == {MANT_W{1'b0}}) begin
                        state_q <= ROUND;
                    end else if (mant_q[CARRY_IDX]) begin
                        // The bit shifted out below S folds into the new sticky.
                        mant_q  <= {1'b0, mant_q[MANT_W-1:2], mant_q[R_IDX] | mant_q[S_IDX]};
                        exp_q   <= exp_q + EXP_ONE_C;
                        state_q <= ROUND;
                    end else if (mant_q[HID_IDX]) begin
                        state_q <= ROUND;
                    end else if (exp_q <= EXP_ONE_C) begin
                        ufl_q   <= 1'b1;
                        state_q <= ROUND;
                    end else begin
                        mant_q  <= {mant_q[MANT_W-2:0], 1'b0};
                        exp_q   <= exp_q - EXP_ONE_C;
                        state_q <= NORM;
                    end
                end
                ROUND: begin
                    result_q    <= result_d;
                    ovf_q       <= ovf_d;
                    unf_q       <= unf_d;
                    inx_q       <= inx_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        state_q     <= DONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_result    = result_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = unf_q;
    assign out_inexact   = inx_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed bench for fp_normalize_round: hand-computed results, flags and latencies.
module tb_fp_normalize_round;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [27:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        s;
        logic [9:0]  e;
        logic [27:0] m;
        logic [31:0] r;
        logic [2:0]  f;
        int          lat;
    } vec_t;

    fp_normalize_round dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_mant       (in_mant),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [27:0] mk(input logic c, input logic h, input logic [22:0] fr, input logic [2:0] grs);
        return {c, h, fr, grs};
    endfunction

    // Present one operand, wait for the result; lat=-1 when a wait bound expires.
    task automatic do_op(input logic s, input logic [9:0] e, input logic [27:0] m, input bit release_out,
                         output logic [31:0] r, output logic [2:0] f, output int lat);
        int n;
        lat = -1;
        r   = 32'h0;
        f   = 3'b000;
        n   = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 60) begin
            @(posedge clk); #1; n++;
        end
        if (out_valid) begin
            lat = n;
            r   = out_result;
            f   = {out_overflow, out_underflow, out_inexact};
        end
        if (release_out) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++; $display("FAIL reset_hs got={in_ready,out_valid}=%b want=10", {in_ready, out_valid});
        end
        total++;
        if ({out_result, out_overflow, out_underflow, out_inexact} !== 35'h0) begin
            bad++; $display("FAIL reset_out got=%h/%b want=0/000", out_result, {out_overflow, out_underflow, out_inexact});
        end
    endtask

    task automatic test_normalize();
        vec_t v[5];
        logic [31:0] r; logic [2:0] f; int lat;
        v[0] = '{1'b0, 10'd127, mk(1'b0, 1'b1, 23'h000000, 3'b000), 32'h3F800000, 3'b000, 3};
        v[1] = '{1'b0, 10'd127, mk(1'b1, 1'b1, 23'h000000, 3'b000), 32'h40400000, 3'b000, 3};
        v[2] = '{1'b0, 10'd130, mk(1'b0, 1'b0, 23'h100000, 3'b000), 32'h3F800000, 3'b000, 6};
        v[3] = '{1'b0, 10'd150, mk(1'b0, 1'b0, 23'h000000, 3'b100), 32'h3F000000, 3'b000, 27};
        v[4] = '{1'b1, 10'd127, mk(1'b1, 1'b1, 23'h000000, 3'b000), 32'hC0400000, 3'b000, 3};
        for (int i = 0; i < 5; i++) begin
            do_op(v[i].s, v[i].e, v[i].m, 1'b1, r, f, lat);
            total++;
            if (r !== v[i].r) begin bad++; $display("FAIL norm[%0d] result got=%h want=%h", i, r, v[i].r); end
            total++;
            if (f !== v[i].f) begin bad++; $display("FAIL norm[%0d] flags got=%b want=%b", i, f, v[i].f); end
            total++;
            if (lat !== v[i].lat) begin bad++; $display("FAIL norm[%0d] latency got=%0d want=%0d", i, lat, v[i].lat); end
        end
    endtask

    task automatic test_rne();
        vec_t v[5];
        logic [31:0] r; logic [2:0] f; int lat;
        v[0] = '{1'b0, 10'd127, mk(1'b0, 1'b1, 23'h000000, 3'b100), 32'h3F800000, 3'b001, 3};
        v[1] = '{1'b0, 10'd127, mk(1'b0, 1'b1, 23'h000001, 3'b100), 32'h3F800002, 3'b001, 3};
        v[2] = '{1'b0, 10'd127, mk(1'b0, 1'b1, 23'h7FFFFF, 3'b100), 32'h40000000, 3'b001, 3};
        v[3] = '{1'b0, 10'd127, mk(1'b0, 1'b1, 23'h000001, 3'b011), 32'h3F800001, 3'b001, 3};
        v[4] = '{1'b0, 10'd127, mk(1'b0, 1'b1, 23'h000000, 3'b101), 32'h3F800001, 3'b001, 3};
        for (int i = 0; i < 5; i++) begin
            do_op(v[i].s, v[i].e, v[i].m, 1'b1, r, f, lat);
            total++;
            if (r !== v[i].r) begin bad++; $display("FAIL rne[%0d] result got=%h want=%h", i, r, v[i].r); end
            total++;
            if (f !== v[i].f) begin bad++; $display("FAIL rne[%0d] flags got=%b want=%b", i, f, v[i].f); end
        end
    endtask

    task automatic test_range();
        vec_t v[6];
        logic [31:0] r; logic [2:0] f; int lat;
        v[0] = '{1'b0, 10'd254, mk(1'b0, 1'b1, 23'h7FFFFF, 3'b110), 32'h7F800000, 3'b101, 3};
        v[1] = '{1'b1, 10'd255, mk(1'b0, 1'b1, 23'h000000, 3'b000), 32'hFF800000, 3'b101, 3};
        v[2] = '{1'b0, 10'd1,   mk(1'b0, 1'b0, 23'h400000, 3'b000), 32'h00000000, 3'b011, 3};
        v[3] = '{1'b1, 10'h3FD, mk(1'b0, 1'b1, 23'h000000, 3'b000), 32'h80000000, 3'b011, 3};
        v[4] = '{1'b0, 10'd1,   mk(1'b0, 1'b1, 23'h000000, 3'b000), 32'h00800000, 3'b000, 3};
        v[5] = '{1'b1, 10'd127, mk(1'b0, 1'b0, 23'h000000, 3'b000), 32'h00000000, 3'b000, 3};
        for (int i = 0; i < 6; i++) begin
            do_op(v[i].s, v[i].e, v[i].m, 1'b1, r, f, lat);
            total++;
            if (r !== v[i].r) begin bad++; $display("FAIL range[%0d] result got=%h want=%h", i, r, v[i].r); end
            total++;
            if (f !== v[i].f) begin bad++; $display("FAIL range[%0d] flags got=%b want=%b", i, f, v[i].f); end
            total++;
            if (lat !== v[i].lat) begin bad++; $display("FAIL range[%0d] latency got=%0d want=%0d", i, lat, v[i].lat); end
        end
    endtask

    task automatic test_hold();
        logic [31:0] r; logic [2:0] f; int lat;
        do_op(1'b1, 10'd127, mk(1'b1, 1'b1, 23'h000000, 3'b000), 1'b0, r, f, lat);
        total++;
        if (r !== 32'hC0400000) begin bad++; $display("FAIL hold_first got=%h want=C0400000", r); end
        // A competing operand while busy must be ignored.
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 10'd127; in_mant = mk(1'b0, 1'b1, 23'h000000, 3'b000);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if ({out_valid, in_ready, out_result} !== {2'b10, 32'hC0400000}) begin
                bad++; $display("FAIL hold[%0d] got valid=%b ready=%b result=%h want 1/0/C0400000", i, out_valid, in_ready, out_result);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++; $display("FAIL hold_release got={in_ready,out_valid}=%b want=10", {in_ready, out_valid});
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; logic [2:0] f; int lat;
        bit saw_valid;
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 10'd150; in_mant = mk(1'b0, 1'b0, 23'h000000, 3'b100);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        #2;
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++; $display("FAIL rst_mid_in got={in_ready,out_valid}=%b want=10", {in_ready, out_valid});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        total++;
        if (saw_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_stale got out_valid=1 want=0"); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b want=1", in_ready); end
        do_op(1'b0, 10'd128, mk(1'b0, 1'b1, 23'h000000, 3'b000), 1'b1, r, f, lat);
        total++;
        if ({r, f} !== {32'h40000000, 3'b000}) begin
            bad++; $display("FAIL rst_mid_after got=%h/%b want=40000000/000", r, f);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = 10'd0; in_mant = 28'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_normalize();
        test_rne();
        test_range();
        test_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
